// File: rtl/des_pkg.sv
// Shared constants and types for the DES S-box substitution engine:
// the eight S-box tables, the P permutation and the engine state encoding.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SUBST,
    DONE
  } state_t;

  // Each entry is one table row. Element [0] is the leftmost nibble, which is column 0.
  // Lookup form: SBOX[box][row][col].
  localparam logic [0:15][3:0] SBOX [8][4] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

  // Output bit i (DES numbering, 1-based) takes input bit P_TABLE[i-1].
  localparam int unsigned P_TABLE [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

endpackage

// File: rtl/des_sbox_engine_if.sv
// Valid/ready block input and result output channels of the S-box engine.
interface des_sbox_engine_if;
  logic        in_valid;
  logic        in_ready;
  logic [48:1] in_block;
  logic        perm_en;
  logic        out_valid;
  logic        out_ready;
  logic [32:1] out_data;

  modport master (
    output in_valid, in_block, perm_en, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_block, perm_en, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/des_sbox_lut.sv
// Single DES S-box lookup: the outer bits select the row and the inner four bits select the column.
module des_sbox_lut
  import des_pkg::*;
(
  input  logic [2:0] box,
  input  logic [5:0] bits,
  output logic [3:0] value
);
  always_comb begin
    value = SBOX[box][{bits[5], bits[0]}][bits[4:1]];
  end
endmodule

// File: rtl/des_sbox_engine.sv
// Multi-cycle DES S-box substitution with optional P permutation.
// It evaluates LANES boxes per cycle over 8/LANES cycles.
module des_sbox_engine
  import des_pkg::*;
#(
  parameter int LANES   = 2,
  parameter bit PERM_EN = 1'b1
) (
  input  logic             clk,
  input  logic             n_rst,
  des_sbox_engine_if.slave bus,
  output logic             busy
);
  localparam int GROUPS = 8 / LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
  end

  state_t        state;
  logic [GW-1:0] grp;
  logic [47:0]   blk;
  logic          perm_q;
  logic [31:0]   acc;
  logic [31:0]   acc_next;
  logic [31:0]   perm_data;
  logic [2:0]    box_idx [LANES];
  logic [3:0]    sub     [LANES];

  // Box n (0-based) reads blk[47-6n -: 6] and writes acc[31-4n -: 4].
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign box_idx[g] = 3'(int'(grp) * LANES + g);
    des_sbox_lut u_lut (
      .box   (box_idx[g]),
      .bits  (6'(blk >> (42 - 6 * int'(box_idx[g])))),
      .value (sub[g])
    );
  end

  always_comb begin
    acc_next = acc;
    for (int unsigned l = 0; l < LANES; l++) begin
      acc_next = (acc_next & ~(32'hF << (28 - 4 * box_idx[l])))
               | (32'(sub[l]) << (28 - 4 * box_idx[l]));
    end
  end

  if (PERM_EN) begin : g_perm
    for (genvar i = 0; i < 32; i++) begin : g_bit
      assign perm_data[31-i] = acc[32-P_TABLE[i]];
    end
  end else begin : g_no_perm
    assign perm_data = acc;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state  <= IDLE;
      grp    <= '0;
      blk    <= '0;
      perm_q <= 1'b0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            blk    <= bus.in_block;
            perm_q <= bus.perm_en & PERM_EN;
            grp    <= '0;
            acc    <= '0;
            state  <= SUBST;
          end
        end
        SUBST: begin
          acc <= acc_next;
          grp <= grp + 1'b1;
          if (grp == GW'(GROUPS - 1)) state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign busy          = (state != IDLE);
  assign bus.out_data  = perm_q ? perm_data : acc;

endmodule

// File: tb/tb_des_sbox_engine.sv
// Directed bench for des_sbox_engine.
// It drives one engine per LANES value plus a build without the P hardware.
module tb_des_sbox_engine;
  localparam int N = 5;

  localparam logic [47:0] BLK_A    = 48'b011000010001011110111010100001100110010100100111;
  localparam logic [47:0] BLK_ZERO = 48'h0;
  localparam logic [47:0] BLK_ONES = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] A_RAW    = 32'h5C82B597;
  localparam logic [31:0] A_PERM   = 32'h234AA9BB;
  localparam logic [31:0] Z_RAW    = 32'hEFA72C4D;
  localparam logic [31:0] ONES_RAW = 32'hD9CE3DCB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst;
  logic        iv   [N];
  logic [47:0] ib   [N];
  logic        pe   [N];
  logic        ordy [N];
  logic        ir   [N];
  logic        ov   [N];
  logic [31:0] od   [N];
  logic        bz   [N];

  int passed = 0;
  int total  = 0;

  function automatic int lanes_of(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      3:       return 8;
      default: return 2;
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    des_sbox_engine_if bus ();
    assign bus.in_valid  = iv[g];
    assign bus.in_block  = ib[g];
    assign bus.perm_en   = pe[g];
    assign bus.out_ready = ordy[g];
    assign ir[g]         = bus.in_ready;
    assign ov[g]         = bus.out_valid;
    assign od[g]         = bus.out_data;
    des_sbox_engine #(.LANES(lanes_of(g)), .PERM_EN(g != 4)) u_dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.slave),
      .busy  (bz[g])
    );
  end

  // Accept one block, scramble the inputs, wait for out_valid, then consume the result.
  task automatic run_block(input int idx, input logic [47:0] blk, input logic perm,
                           output logic [31:0] data, output int lat);
    ib[idx] = blk;
    pe[idx] = perm;
    iv[idx] = 1'b1;
    @(posedge clk); #1;
    iv[idx] = 1'b0;
    ib[idx] = ~blk;
    pe[idx] = ~perm;
    lat = 0;
    while (!ov[idx] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ov[idx]) lat = -1;
    data = od[idx];
    ordy[idx] = 1'b1;
    @(posedge clk); #1;
    ordy[idx] = 1'b0;
  endtask

  task automatic test_reset();
    for (int g = 0; g < N; g++) begin
      total++;
      if (ir[g] !== 1'b1) $display("FAIL reset_in_ready[%0d]: got %b want 1", g, ir[g]);
      else passed++;
      total++;
      if (ov[g] !== 1'b0) $display("FAIL reset_out_valid[%0d]: got %b want 0", g, ov[g]);
      else passed++;
      total++;
      if (od[g] !== 32'h0) $display("FAIL reset_out_data[%0d]: got %h want 00000000", g, od[g]);
      else passed++;
      total++;
      if (bz[g] !== 1'b0) $display("FAIL reset_busy[%0d]: got %b want 0", g, bz[g]);
      else passed++;
    end
  endtask

  task automatic test_raw_vector();
    logic [31:0] d;
    int lat;
    run_block(1, BLK_A, 1'b0, d, lat);
    total++;
    if (lat !== 4) $display("FAIL raw_latency: got %0d want 4", lat);
    else passed++;
    total++;
    if (d !== A_RAW) $display("FAIL raw_data: got %h want %h", d, A_RAW);
    else passed++;
  endtask

  task automatic test_perm_all_lanes();
    logic [31:0] d;
    int lat;
    for (int g = 0; g < 4; g++) begin
      run_block(g, BLK_A, 1'b1, d, lat);
      total++;
      if (lat !== 8 / lanes_of(g))
        $display("FAIL perm_latency[L%0d]: got %0d want %0d", lanes_of(g), lat, 8 / lanes_of(g));
      else passed++;
      total++;
      if (d !== A_PERM) $display("FAIL perm_data[L%0d]: got %h want %h", lanes_of(g), d, A_PERM);
      else passed++;
    end
  endtask

  task automatic test_row_col_extremes();
    logic [31:0] d;
    int lat;
    run_block(1, BLK_ZERO, 1'b0, d, lat);
    total++;
    if (d !== Z_RAW) $display("FAIL zero_block: got %h want %h", d, Z_RAW);
    else passed++;
    run_block(3, BLK_ONES, 1'b0, d, lat);
    total++;
    if (d !== ONES_RAW) $display("FAIL ones_block_L8: got %h want %h", d, ONES_RAW);
    else passed++;
    run_block(0, BLK_ONES, 1'b0, d, lat);
    total++;
    if (d !== ONES_RAW) $display("FAIL ones_block_L1: got %h want %h", d, ONES_RAW);
    else passed++;
  endtask

  task automatic test_perm_disabled();
    logic [31:0] d;
    int lat;
    run_block(4, BLK_A, 1'b1, d, lat);
    total++;
    if (lat !== 4) $display("FAIL noperm_latency: got %0d want 4", lat);
    else passed++;
    total++;
    if (d !== A_RAW) $display("FAIL noperm_data: got %h want %h", d, A_RAW);
    else passed++;
  endtask

  task automatic test_backpressure();
    int wait_cyc;
    bit saw;
    ib[1] = BLK_A; pe[1] = 1'b1; iv[1] = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    wait_cyc = 0;
    while (!ov[1] && wait_cyc < 20) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    for (int c = 0; c < 5; c++) begin
      iv[1] = (c == 2);
      ib[1] = (c == 2) ? BLK_ZERO : BLK_ONES;
      pe[1] = 1'b0;
      @(posedge clk); #1;
      total++;
      if (ov[1] !== 1'b1) $display("FAIL bp_out_valid[%0d]: got %b want 1", c, ov[1]);
      else passed++;
      total++;
      if (od[1] !== A_PERM) $display("FAIL bp_out_data[%0d]: got %h want %h", c, od[1], A_PERM);
      else passed++;
      total++;
      if (ir[1] !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", c, ir[1]);
      else passed++;
      total++;
      if (bz[1] !== 1'b1) $display("FAIL bp_busy[%0d]: got %b want 1", c, bz[1]);
      else passed++;
    end
    iv[1] = 1'b0;
    ordy[1] = 1'b1;
    @(posedge clk); #1;
    ordy[1] = 1'b0;
    total++;
    if (ov[1] !== 1'b0 || ir[1] !== 1'b1 || bz[1] !== 1'b0)
      $display("FAIL bp_release: got valid=%b ready=%b busy=%b want 0 1 0", ov[1], ir[1], bz[1]);
    else passed++;
    saw = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ov[1]) saw = 1'b1;
    end
    total++;
    if (saw !== 1'b0) $display("FAIL bp_ignored_pulse: got out_valid=1 want no output");
    else passed++;
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    int lat;
    bit saw;
    ib[0] = BLK_A; pe[0] = 1'b1; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    total++;
    if (ov[0] !== 1'b0) $display("FAIL abort_out_valid: got %b want 0", ov[0]);
    else passed++;
    total++;
    if (od[0] !== 32'h0) $display("FAIL abort_out_data: got %h want 00000000", od[0]);
    else passed++;
    total++;
    if (ir[0] !== 1'b1 || bz[0] !== 1'b0)
      $display("FAIL abort_idle: got ready=%b busy=%b want 1 0", ir[0], bz[0]);
    else passed++;
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ov[0]) saw = 1'b1;
    end
    total++;
    if (saw !== 1'b0) $display("FAIL abort_no_result: got out_valid=1 want none");
    else passed++;
    run_block(0, BLK_ZERO, 1'b0, d, lat);
    total++;
    if (lat !== 8) $display("FAIL abort_fresh_latency: got %0d want 8", lat);
    else passed++;
    total++;
    if (d !== Z_RAW) $display("FAIL abort_fresh_data: got %h want %h", d, Z_RAW);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [47:0] vb  [4];
    logic        vp  [4];
    logic [31:0] exp [4];
    int nacc, nout, last, cyc;
    bit took;
    vb = '{BLK_A, BLK_A, BLK_ZERO, BLK_ONES};
    vp = '{1'b0, 1'b1, 1'b0, 1'b0};
    exp = '{A_RAW, A_PERM, Z_RAW, ONES_RAW};
    nacc = 0; nout = 0; last = 0; cyc = 0;
    ordy[2] = 1'b1;
    ib[2] = vb[0]; pe[2] = vp[0]; iv[2] = 1'b1;
    while (nout < 4 && cyc < 100) begin
      took = iv[2] && ir[2];
      @(posedge clk); #1;
      cyc++;
      if (took) begin
        nacc++;
        if (nacc < 4) begin
          ib[2] = vb[nacc];
          pe[2] = vp[nacc];
        end else begin
          iv[2] = 1'b0;
        end
      end
      if (ov[2]) begin
        total++;
        if (od[2] !== exp[nout]) $display("FAIL b2b_data[%0d]: got %h want %h", nout, od[2], exp[nout]);
        else passed++;
        if (nout > 0) begin
          total++;
          if (cyc - last !== 8 / 4 + 2)
            $display("FAIL b2b_spacing[%0d]: got %0d want %0d", nout, cyc - last, 8 / 4 + 2);
          else passed++;
        end
        last = cyc;
        nout++;
      end
    end
    total++;
    if (nout !== 4) $display("FAIL b2b_count: got %0d want 4", nout);
    else passed++;
    iv[2] = 1'b0;
    ordy[2] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

  initial begin
    for (int g = 0; g < N; g++) begin
      iv[g] = 1'b0; ib[g] = '0; pe[g] = 1'b0; ordy[g] = 1'b0;
    end
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    test_reset();
    test_raw_vector();
    test_perm_all_lanes();
    test_row_col_extremes();
    test_perm_disabled();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/des_sbox_engine.md
# des_sbox_engine

Multi-cycle, parametrised DES S-box substitution engine for the 3DES datapath. It accepts one 48-bit expanded, key-mixed block over a valid/ready handshake. It evaluates the eight DES S-boxes `LANES` at a time over `8/LANES` cycles, optionally applies the P permutation, and presents the 32-bit result on a second valid/ready handshake. It sits between the E-expansion/key-XOR stage and the Feistel XOR in the round logic.

## Interface
- `LANES`, default 2: S-boxes evaluated per cycle. Legal values are 1, 2, 4, 8; any other value is an elaboration error.
- `PERM_EN`, default 1: when 1, P permutation hardware is instantiated; when 0, `perm_en` is ignored and the raw substitution output is returned.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `n_rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  `in_block` holds a valid block.
- `in_ready`  out  1  engine can accept a block.
- `in_block`  in  48 `[48:1]`  DES numbering: bit 48 is DES bit 1; S-box k uses `in_block[54-6k -: 6]`.
- `perm_en`  in  1  apply P to the result; sampled with the block.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts `out_data`.
- `out_data`  out  32 `[32:1]`  substituted (and optionally permuted) result; S1 output occupies `[32:29]`.
- `busy`  out  1  high in SUBST and DONE.

## Operation
- FSM states: IDLE, SUBST, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`: capture `in_block` and `perm_en`, clear group counter `grp`, clear the 32-bit accumulator, go to SUBST.
- SUBST:
  - Each cycle, boxes `grp*LANES+1 .. grp*LANES+LANES` are looked up. Row = outer bits (b1,b6); column = inner bits (b2..b5).
  - The 4-bit results are written into their fixed accumulator nibbles.
  - `grp` increments. When `grp == 8/LANES-1`, go to DONE.
  - `grp` width is `max(1,$clog2(8/LANES))`.
- DONE:
  - `out_valid`=1.
  - `out_data` = P(acc) if the captured `perm_en`=1 and `PERM_EN`=1; otherwise `out_data` = acc.
  - On `out_ready`: go to IDLE.
- `in_ready` is high only in IDLE. Inputs outside IDLE are ignored, and a changing `in_block` outside acceptance has no effect.
- `out_data` and `out_valid` are held stable while `out_valid & !out_ready`.
- Reset while `n_rst`=0 at an edge:
  - state goes to IDLE, `grp`=0, acc=0, captured `perm_en`=0.
  - An in-flight block is discarded and no output is produced for it.
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `busy`=0.

## Timing
- Block accepted at edge t: SUBST occupies cycles t+1 .. t+8/LANES, and `out_valid` rises after edge t+8/LANES.
- Latency is therefore 8/LANES cycles: LANES=1 gives 8, LANES=2 gives 4, LANES=8 gives 1.
- With `out_ready` held high, output is consumed one cycle after `out_valid` rises. IDLE is re-entered, and the next accept happens at the following edge.
- Sustained throughput is one block per 8/LANES+2 cycles.
- No combinational path from `in_valid` or `out_ready` to any output. `in_ready`, `out_valid` and `busy` decode from state registers only.

## Structure
- Package `des_pkg`:
  - The eight 64×4 S-box tables as a constant array indexed [box][row][col].
  - The 32-entry P permutation table.
  - The FSM state enum.
- Sub-module `des_sbox_lut`: combinational single-box lookup with 3-bit box index, 6-bit input and 4-bit output. It is instantiated `LANES` times with a generate loop.
- P permutation is a generate-for over the package table. It is gated by `PERM_EN`.

## Test plan
- `in_block`=48'b011000010001011110111010100001100110010100100111, `perm_en`=0, LANES=2: `out_valid` 4 cycles after accept, `out_data`=32'h5C82B597.
- Same block, `perm_en`=1: `out_data`=32'h234AA9BB. Run this for every LANES value in {1,2,4,8} and check latency is 8, 4, 2, 1 cycles respectively.
- `in_block`=0, `perm_en`=0: `out_data`=32'hEFA72C4D, i.e. row 0, col 0 of S1..S8.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE. Required: `out_valid` and `out_data` stable, `in_ready`=0, a new `in_valid` pulse ignored. After `out_ready`=1, return to IDLE with `in_ready`=1.
- Assert `n_rst`=0 for one edge in the second SUBST cycle (LANES=1). Required: next cycle in IDLE with `out_valid`=0 and `out_data`=0, and no result for the aborted block. A fresh block then gives the correct result.
- Back-to-back blocks with `in_valid` and `out_ready` always high: one result per 8/LANES+2 cycles, in order, each matching the reference model.
